hdlc_tx_ctrl: RTL
=================

// Module: hdlc_tx_ctrl
// PURPOSE
//  Bit-level sequencer for the HDLC transmit path. Emits one line bit per Clk:
//   - idle ones, start flag, stuffed data bytes from the Tx buffer, optional FCS,
//     end flag, and the abort pattern.
//  Drives buffer read strobes and FCS-unit control. Sits between Tx buffer/FCS unit and line.
// PARAMETERS
//  MAX_FRAME_BYTES  126  largest accepted Tx_FrameSize; larger values clamp to this
//  STUFF_LIMIT      5    consecutive data/FCS ones before a stuffed 0
// PORTS
//  Clk              in   1  clock; all logic on posedge
//  Rst              in   1  reset, synchronous, active-high
//  Tx_Enable        in   1  start request, sampled in IDLE
//  Tx_AbortFrame    in   1  abort request
//  Tx_FrameSize     in   8  data bytes in frame, latched at start
//  Tx_DataOutBuff   in   8  buffer byte, valid 1 cycle after Tx_RdBuff, held until next strobe
//  Tx_FCSByte       in   8  FCS byte, valid 1 cycle after Tx_WriteFCS
//  Tx               out  1  serial line bit, LSB first, registered
//  Tx_RdBuff        out  1  1-cycle pulse: pop next buffer byte
//  Tx_NewByte       out  1  1-cycle pulse: Tx_Data loaded with new data byte
//  Tx_Data          out  8  byte currently shifting
//  Tx_ValidFrame    out  1  high in START_FLAG, DATA, FCS
//  Tx_Done          out  1  high when idle/ready for a new frame
//  Tx_AbortedTrans  out  1  1-cycle pulse: abort accepted
//  Tx_StartFCS      out  1  1-cycle pulse: clear FCS unit
//  Tx_WriteFCS      out  1  1-cycle pulse: request next FCS byte
// BEHAVIOUR
//  Reset: state IDLE; Tx=1; Tx_Done=1; Tx_Data=0; all other outputs 0. Takes effect at the next edge from any state.
//  FSM: IDLE -> START_FLAG(8) -> DATA -> [FCS(16 bits)] -> END_FLAG(8) -> IDLE; also ABORT(8) -> IDLE.
//  IDLE: Tx=1.
//   - Tx_Enable=1 with FrameSize!=0 at edge t: START_FLAG, first flag bit on Tx at t+1, Tx_Done=0.
//   - FrameSize=0: request ignored.
//   - Tx_Enable is ignored outside IDLE.
//  Flags: 0,1,1,1,1,1,1,0 (8'h7E LSB first). Flags are never stuffed and do not update the ones count.
//  Byte fetch:
//   - Tx_RdBuff pulses once on the cycle bit 6 of the current flag/byte is sent.
//   - No pulse during the last data byte.
//   - The byte loads into the shift register after bit 7, with a Tx_NewByte pulse.
//  Zero insertion (DATA, FCS only):
//   - After STUFF_LIMIT consecutive 1s, the next cycle sends 0 and the ones counter clears.
//   - The bit index holds during this stall, so strobes fire once per byte.
//   - The ones counter clears on entry to DATA.
//  Byte counter: 7 bits, counts bytes sent. The last byte is when count == latched size-1.
//  END_FLAG: Tx_ValidFrame=0. After its last bit -> IDLE and Tx_Done=1 on the same edge.
//  Abort:
//   - Sampled in START_FLAG/DATA/FCS, including stall cycles, at edge t.
//   - At t+1: ABORT; Tx_AbortedTrans=1 for 1 cycle; Tx_ValidFrame=0; Tx sends 0 then seven 1s.
//   - Then IDLE.
//   - Ignored in IDLE, END_FLAG and ABORT.
//   - Abort on the last FCS bit wins over END_FLAG.
//  Tx_Enable with abort in IDLE: start proceeds.
// CONFIGURATION
//  HDLC_TX_FCS_EN defined:
//   - Tx_StartFCS pulses on the first START_FLAG cycle.
//   - After the last data byte, FCS sends 2 bytes, low byte first, from Tx_FCSByte.
//   - Tx_WriteFCS pulses at bit 6 of the last data byte and of the first FCS byte.
//   - FCS bits are stuffed.
//  Undefined: DATA -> END_FLAG directly. Tx_StartFCS=Tx_WriteFCS=0; Tx_FCSByte unused.
// STRUCTURE
//  hdlc_pkg: typedef enum tx_state_t {IDLE,START_FLAG,DATA,FCS,END_FLAG,ABORT}.
//  hdlc_pkg constants: HDLC_FLAG=8'h7E, HDLC_ABORT=8'hFE, HDLC_MAX_FRAME=126.
//  Sub-module hdlc_bit_stuffer: ones counter plus stall/stuff flag. Inputs: bit, enable, clear. Output: stuff.
//  Top holds FSM, bit/byte counters, shift register and strobes.
// TESTING
//  1. No FCS, size=1, byte 8'h00 -> Tx=01111110_00000000_01111110 then 1s.
//     Tx_Done low exactly 24 cycles; Tx_RdBuff pulses once.
//  2. Byte 8'hFF -> data bits 11111_0_111: byte spans 9 cycles, one Tx_NewByte.
//     Flags are unstuffed.
//  3. size=4, Tx_AbortFrame during byte 2 -> next cycle Tx_AbortedTrans pulse and Tx_ValidFrame=0.
//     Tx=0,1,1,1,1,1,1,1, then IDLE with Tx_Done=1. No further Tx_RdBuff.
//  4. Tx_FrameSize=0 with Tx_Enable -> Tx stays 1, Tx_Done stays 1, no strobes.
//  5. HDLC_TX_FCS_EN, size=2, FCS bytes 8'h12, 8'h34:
//     - 1 Tx_StartFCS, 2 Tx_NewByte, 2 Tx_WriteFCS pulses.
//     - 16 FCS bits 01001000_00101100 before the end flag.
//  6. Rst=1 mid-FCS -> next cycle Tx=1, Tx_Done=1, Tx_ValidFrame=0, no pulses.
//     A new Tx_Enable starts a clean frame.

Source files
------------

// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC transmit path.
package hdlc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_FLAG,
        DATA,
        FCS,
        END_FLAG,
        ABORT
    } tx_state_t;

    localparam logic [7:0] HDLC_FLAG = 8'h7E;
    localparam logic [7:0] HDLC_ABORT = 8'hFE;
    localparam int HDLC_MAX_FRAME = 126;

endpackage

// File: rtl/hdlc_bit_stuffer.sv
// Ones counter for HDLC zero insertion; stuff flags that the next line bit
// must be a stuffed 0.
import hdlc_pkg::*;

module hdlc_bit_stuffer #(
    parameter int STUFF_LIMIT = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_bit,
    input  logic enable,
    input  logic clear,
    output logic stuff
);

    localparam int CW = $clog2(STUFF_LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(STUFF_LIMIT - 1);

    logic [CW-1:0] ones;

    assign stuff = enable && tx_bit && (ones == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ones <= '0;
        end else if (enable) begin
            ones <= (tx_bit && !stuff) ? ones + 1'b1 : '0;
        end
    end

endmodule

// File: rtl/hdlc_tx_ctrl.sv
// HDLC transmit bit sequencer: flags, stuffed data, optional FCS, abort.
// Define HDLC_TX_FCS_EN to append the two FCS bytes after the data.
import hdlc_pkg::*;

module hdlc_tx_ctrl #(
    parameter int MAX_FRAME_BYTES = HDLC_MAX_FRAME,
    parameter int STUFF_LIMIT = 5
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Enable,
    input  logic       Tx_AbortFrame,
    input  logic [7:0] Tx_FrameSize,
    input  logic [7:0] Tx_DataOutBuff,
    input  logic [7:0] Tx_FCSByte,
    output logic       Tx,
    output logic       Tx_RdBuff,
    output logic       Tx_NewByte,
    output logic [7:0] Tx_Data,
    output logic       Tx_ValidFrame,
    output logic       Tx_Done,
    output logic       Tx_AbortedTrans,
    output logic       Tx_StartFCS,
    output logic       Tx_WriteFCS
);

    localparam logic [7:0] MAX_SIZE = 8'(MAX_FRAME_BYTES);

    tx_state_t  state;
    logic [2:0] bit_idx;
    logic       stall;
    logic       tx_q;
    logic       new_byte_q;
    logic       aborted_q;
    logic [6:0] size_l;
    logic [6:0] byte_cnt;
    logic [7:0] data_q;
`ifdef HDLC_TX_FCS_EN
    logic       fcs_idx;
`endif

    logic       framing;
    logic       payload;
    logic       last_byte;
    logic       bit6;
    logic       next_bit;
    logic       stuff;
    logic [7:0] cur_byte;

    always_comb begin
        framing   = (state == START_FLAG) || (state == DATA) || (state == FCS);
        payload   = (state == DATA) || (state == FCS);
        last_byte = (byte_cnt == size_l - 7'd1);
        bit6      = (bit_idx == 3'd6) && !stall;
        cur_byte  = HDLC_FLAG;
        if (payload) begin
            cur_byte = data_q;
        end else if (state == ABORT) begin
            cur_byte = HDLC_ABORT;
        end
        next_bit = cur_byte[bit_idx + 3'd1];
    end

    hdlc_bit_stuffer #(
        .STUFF_LIMIT(STUFF_LIMIT)
    ) u_stuffer (
        .clk   (Clk),
        .rst   (Rst),
        .tx_bit(tx_q),
        .enable(payload && !stall),
        .clear (!payload),
        .stuff (stuff)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            bit_idx    <= '0;
            stall      <= 1'b0;
            tx_q       <= 1'b1;
            data_q     <= '0;
            size_l     <= '0;
            byte_cnt   <= '0;
            new_byte_q <= 1'b0;
            aborted_q  <= 1'b0;
`ifdef HDLC_TX_FCS_EN
            fcs_idx    <= 1'b0;
`endif
        end else begin
            new_byte_q <= 1'b0;
            aborted_q  <= 1'b0;
            if (framing && Tx_AbortFrame) begin
                state     <= ABORT;
                tx_q      <= HDLC_ABORT[0];
                bit_idx   <= '0;
                stall     <= 1'b0;
                aborted_q <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        tx_q <= 1'b1;
                        if (Tx_Enable && (Tx_FrameSize != 8'd0)) begin
                            state   <= START_FLAG;
                            tx_q    <= HDLC_FLAG[0];
                            bit_idx <= '0;
                            size_l  <= (Tx_FrameSize > MAX_SIZE) ?
                                       MAX_SIZE[6:0] : Tx_FrameSize[6:0];
                        end
                    end
                    START_FLAG: begin
                        if (bit_idx == 3'd7) begin
                            state      <= DATA;
                            data_q     <= Tx_DataOutBuff;
                            tx_q       <= Tx_DataOutBuff[0];
                            bit_idx    <= '0;
                            byte_cnt   <= '0;
                            new_byte_q <= 1'b1;
                        end else begin
                            tx_q    <= next_bit;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    DATA, FCS: begin
                        // bit index holds while the stuffed 0 is on the line
                        if (stuff) begin
                            tx_q  <= 1'b0;
                            stall <= 1'b1;
                        end else begin
                            stall <= 1'b0;
                            if (bit_idx != 3'd7) begin
                                tx_q    <= next_bit;
                                bit_idx <= bit_idx + 3'd1;
                            end else if ((state == DATA) && !last_byte) begin
                                data_q     <= Tx_DataOutBuff;
                                tx_q       <= Tx_DataOutBuff[0];
                                bit_idx    <= '0;
                                byte_cnt   <= byte_cnt + 7'd1;
                                new_byte_q <= 1'b1;
`ifdef HDLC_TX_FCS_EN
                            end else if ((state == DATA) || !fcs_idx) begin
                                state   <= FCS;
                                fcs_idx <= (state == FCS);
                                data_q  <= Tx_FCSByte;
                                tx_q    <= Tx_FCSByte[0];
                                bit_idx <= '0;
`endif
                            end else begin
                                state   <= END_FLAG;
                                tx_q    <= HDLC_FLAG[0];
                                bit_idx <= '0;
                            end
                        end
                    end
                    END_FLAG, ABORT: begin
                        if (bit_idx == 3'd7) begin
                            state <= IDLE;
                            tx_q  <= 1'b1;
                        end else begin
                            tx_q    <= next_bit;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign Tx              = tx_q;
    assign Tx_Data         = data_q;
    assign Tx_NewByte      = new_byte_q;
    assign Tx_AbortedTrans = aborted_q;
    assign Tx_ValidFrame   = framing;
    assign Tx_Done         = (state == IDLE);
    assign Tx_RdBuff       = bit6 && ((state == START_FLAG) ||
                                      ((state == DATA) && !last_byte));

`ifdef HDLC_TX_FCS_EN
    assign Tx_StartFCS = (state == START_FLAG) && (bit_idx == 3'd0);
    assign Tx_WriteFCS = bit6 && (((state == DATA) && last_byte) ||
                                  ((state == FCS) && !fcs_idx));
`else
    logic unused_fcs;
    assign unused_fcs  = ^Tx_FCSByte;
    assign Tx_StartFCS = 1'b0;
    assign Tx_WriteFCS = 1'b0;
`endif

endmodule
